// File: rtl/axi_write_router.sv
// AXI write-path router: decodes AWADDR, steers AW/W/B to one slave or DECERR sink.
// Define AXI_WR_BEAT_CHECK_EN to count W beats and derive WLAST from AWLEN.
module axi_write_router #(
  parameter int NUM_SLAVES  = 2,
  parameter int REGION_BITS = 16,
  parameter int ID_BITS     = 4,
  parameter int IDS_BITS    = 8,
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BITS   = 32,
  parameter int LEN_BITS    = 4,
  parameter int SIZE_BITS   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IDS_BITS-ID_BITS-1:0] mid,
  input  logic [ID_BITS-1:0]          AWID_M,
  input  logic [ADDR_BITS-1:0]        AWADDR_M,
  input  logic [LEN_BITS-1:0]         AWLEN_M,
  input  logic [SIZE_BITS-1:0]        AWSIZE_M,
  input  logic [1:0]                  AWBURST_M,
  input  logic                        AWVALID_M,
  output logic                        AWREADY_M,
  input  logic [DATA_BITS-1:0]        WDATA_M,
  input  logic [DATA_BITS/8-1:0]      WSTRB_M,
  input  logic                        WLAST_M,
  input  logic                        WVALID_M,
  output logic                        WREADY_M,
  output logic [ID_BITS-1:0]          BID_M,
  output logic [1:0]                  BRESP_M,
  output logic                        BVALID_M,
  input  logic                        BREADY_M,
  output logic [IDS_BITS-1:0]         AWID_S    [NUM_SLAVES],
  output logic [ADDR_BITS-1:0]        AWADDR_S  [NUM_SLAVES],
  output logic [LEN_BITS-1:0]         AWLEN_S   [NUM_SLAVES],
  output logic [SIZE_BITS-1:0]        AWSIZE_S  [NUM_SLAVES],
  output logic [1:0]                  AWBURST_S [NUM_SLAVES],
  output logic [NUM_SLAVES-1:0]       AWVALID_S,
  input  logic [NUM_SLAVES-1:0]       AWREADY_S,
  output logic [DATA_BITS-1:0]        WDATA_S   [NUM_SLAVES],
  output logic [DATA_BITS/8-1:0]      WSTRB_S   [NUM_SLAVES],
  output logic [NUM_SLAVES-1:0]       WLAST_S,
  output logic [NUM_SLAVES-1:0]       WVALID_S,
  input  logic [NUM_SLAVES-1:0]       WREADY_S,
  input  logic [IDS_BITS-1:0]         BID_S     [NUM_SLAVES],
  input  logic [1:0]                  BRESP_S   [NUM_SLAVES],
  input  logic [NUM_SLAVES-1:0]       BVALID_S,
  output logic [NUM_SLAVES-1:0]       BREADY_S,
  output logic                        busy
);

  localparam int SW = $clog2(NUM_SLAVES + 1);
  localparam logic [SW-1:0] DEF = SW'(NUM_SLAVES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]           state;
  logic [SW-1:0]        sel_q;
  logic [ID_BITS-1:0]   id_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [ADDR_BITS-1:0] idx;
  logic                 hit;
  logic [SW-1:0]        dec;
  logic                 aw_hs;
  logic                 w_hs;
  logic                 b_hs;
  logic                 last;
  logic                 err;
  logic [1:0]           resp;

  // Full-width compare so aliased upper idx bits fall to the default slave
  assign idx   = AWADDR_M >> REGION_BITS;
  assign hit   = idx < ADDR_BITS'(NUM_SLAVES);
  assign dec   = hit ? idx[SW-1:0] : DEF;
  assign aw_hs = AWVALID_M & AWREADY_M;
  assign w_hs  = WVALID_M & WREADY_M;
  assign b_hs  = BVALID_M & BREADY_M;
  assign busy  = state != IDLE;

`ifdef AXI_WR_BEAT_CHECK_EN
  logic [LEN_BITS-1:0] cnt;

  assign last = cnt == len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (aw_hs) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (w_hs) begin
      cnt <= cnt + 1'b1;
      if (WLAST_M != last) err <= 1'b1;
    end
  end
`else
  logic unused_len;

  assign last       = WLAST_M;
  assign err        = 1'b0;
  assign unused_len = ^len_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= '0;
      id_q  <= '0;
      len_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (aw_hs) begin
          state <= DATA;
          sel_q <= dec;
          id_q  <= AWID_M;
          len_q <= AWLEN_M;
        end
        DATA: if (w_hs && last) state <= RESP;
        RESP: if (b_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    AWREADY_M = 1'b0;
    WREADY_M  = 1'b0;
    BVALID_M  = 1'b0;
    BID_M     = '0;
    resp      = 2'b00;
    AWVALID_S = '0;
    WLAST_S   = '0;
    WVALID_S  = '0;
    BREADY_S  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      AWID_S[i]    = '0;
      AWADDR_S[i]  = '0;
      AWLEN_S[i]   = '0;
      AWSIZE_S[i]  = '0;
      AWBURST_S[i] = '0;
      WDATA_S[i]   = '0;
      WSTRB_S[i]   = '0;
    end
    unique case (state)
      IDLE: if (!rst) begin
        AWREADY_M = dec == DEF;
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (SW'(i) == dec) begin
            AWVALID_S[i] = AWVALID_M;
            AWID_S[i]    = {AWID_M, mid};
            AWADDR_S[i]  = AWADDR_M;
            AWLEN_S[i]   = AWLEN_M;
            AWSIZE_S[i]  = AWSIZE_M;
            AWBURST_S[i] = AWBURST_M;
            AWREADY_M    = AWREADY_S[i];
          end
        end
      end
      DATA: begin
        WREADY_M = sel_q == DEF;
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (SW'(i) == sel_q) begin
            WDATA_S[i]  = WDATA_M;
            WSTRB_S[i]  = WSTRB_M;
            WLAST_S[i]  = last;
            WVALID_S[i] = WVALID_M;
            WREADY_M    = WREADY_S[i];
          end
        end
      end
      RESP: begin
        if (sel_q == DEF) begin
          BVALID_M = 1'b1;
          BID_M    = id_q;
          resp     = 2'b11;
        end
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (SW'(i) == sel_q) begin
            BVALID_M    = BVALID_S[i];
            BREADY_S[i] = BREADY_M;
            BID_M       = BID_S[i][IDS_BITS-1 -: ID_BITS];
            resp        = BRESP_S[i];
          end
        end
        if (err && resp != 2'b11) resp = 2'b10;
      end
      default: ;
    endcase
    BRESP_M = resp;
  end

  logic [NUM_SLAVES-1:0] unused_bid;

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++)
      unused_bid[i] = ^BID_S[i][IDS_BITS-ID_BITS-1:0];
  end

endmodule

// File: tb/tb_axi_write_router.sv
// Randomised directed bench for axi_write_router with an address-map/beat reference model.
// Honours AXI_WR_BEAT_CHECK_EN when the design is built with it.
`timescale 1ns/1ps
module tb_axi_write_router;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  mid;
  logic [3:0]  AWID_M;
  logic [31:0] AWADDR_M;
  logic [3:0]  AWLEN_M;
  logic [2:0]  AWSIZE_M;
  logic [1:0]  AWBURST_M;
  logic        AWVALID_M, AWREADY_M;
  logic [31:0] WDATA_M;
  logic [3:0]  WSTRB_M;
  logic        WLAST_M, WVALID_M, WREADY_M;
  logic [3:0]  BID_M;
  logic [1:0]  BRESP_M;
  logic        BVALID_M, BREADY_M;
  logic [7:0]  AWID_S    [NS];
  logic [31:0] AWADDR_S  [NS];
  logic [3:0]  AWLEN_S   [NS];
  logic [2:0]  AWSIZE_S  [NS];
  logic [1:0]  AWBURST_S [NS];
  logic [NS-1:0] AWVALID_S, AWREADY_S;
  logic [31:0] WDATA_S   [NS];
  logic [3:0]  WSTRB_S   [NS];
  logic [NS-1:0] WLAST_S, WVALID_S, WREADY_S;
  logic [7:0]  BID_S     [NS];
  logic [1:0]  BRESP_S   [NS];
  logic [NS-1:0] BVALID_S, BREADY_S;
  logic        busy;

  int checks = 0;
  int errors = 0;

  axi_write_router dut (
    .clk(clk), .rst(rst), .mid(mid),
    .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M),
    .AWSIZE_M(AWSIZE_M), .AWBURST_M(AWBURST_M),
    .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
    .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M),
    .WVALID_M(WVALID_M), .WREADY_M(WREADY_M),
    .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M),
    .BREADY_M(BREADY_M),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
    .AWSIZE_S(AWSIZE_S), .AWBURST_S(AWBURST_S),
    .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
    .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
    .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic outs_any();
    logic a;
    a = AWREADY_M | WREADY_M | BVALID_M | busy | (|BID_M) | (|BRESP_M);
    for (int i = 0; i < NS; i++)
      a = a | AWVALID_S[i] | WVALID_S[i] | BREADY_S[i] | WLAST_S[i]
            | (|AWID_S[i]) | (|AWADDR_S[i]) | (|AWLEN_S[i])
            | (|AWSIZE_S[i]) | (|AWBURST_S[i]) | (|WDATA_S[i])
            | (|WSTRB_S[i]);
    return a;
  endfunction

  // One write transaction; the target follows from addr / 64 KiB.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] id,
                         input logic [3:0] len, input logic [3:0] m,
                         input bit tog, input int early, input int abort,
                         input bit hold);
    int s, b, cyc, d;
    bit done, bad, acc;
    logic [1:0] r, er;
    logic [31:0] data [16];
    int got [NS];
    s = ((addr >> 16) < NS) ? int'(addr >> 16) : NS;
    for (int i = 0; i < 16; i++) data[i] = $urandom;
    for (int i = 0; i < NS; i++) got[i] = 0;
    done = 0;
    bad = 0;
    for (cyc = 0; cyc < 50 && !done; cyc++) begin
      @(negedge clk);
      mid = m; AWADDR_M = addr; AWID_M = id; AWLEN_M = len;
      AWSIZE_M = 3'd2; AWBURST_M = 2'd1; AWVALID_M = 1'b1;
      WVALID_M = 1'($urandom); BREADY_M = 1'($urandom);
      for (int i = 0; i < NS; i++) begin
        AWREADY_S[i] = 1'($urandom);
        BVALID_S[i] = 1'($urandom);
      end
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_wready", WREADY_M, 0);
      chk("idle_bvalid", BVALID_M, 0);
      for (int i = 0; i < NS; i++) begin
        chk("idle_wvalid_s", WVALID_S[i], 0);
        chk("idle_bready_s", BREADY_S[i], 0);
        if (i == s) begin
          chk("aw_valid_s", AWVALID_S[i], 1);
          chk("aw_id_s", AWID_S[i], {id, m});
          chk("aw_addr_s", AWADDR_S[i], addr);
          chk("aw_len_s", AWLEN_S[i], len);
          chk("aw_burst_s", AWBURST_S[i], 2'd1);
        end else begin
          chk("aw_other_valid", AWVALID_S[i], 0);
          chk("aw_other_id", AWID_S[i], 0);
          chk("aw_other_addr", AWADDR_S[i], 0);
        end
      end
      if (s < NS) begin
        chk("awready_m", AWREADY_M, AWREADY_S[s]);
        done = AWREADY_S[s];
      end else begin
        chk("awready_def", AWREADY_M, 1);
        chk("aw_def_first_cycle", cyc, 0);
        done = 1;
      end
      @(posedge clk);
    end
    if (!done) begin
      chk("aw_timeout", 0, 1);
      $fatal(1, "aw handshake timeout");
    end

    b = 0;
    for (cyc = 0; cyc < 300 && b <= int'(len); cyc++) begin
      @(negedge clk);
      AWVALID_M = hold;
      AWADDR_M = hold ? 32'h0003_0000 : addr;
      if (abort == b) begin
        rst = 1'b1;
        #1;
        chk("rst_outputs", outs_any(), 0);
        @(negedge clk);
        rst = 1'b0;
        AWVALID_M = 1'b0;
        return;
      end
      WVALID_M = $urandom_range(0, 3) != 0;
      WDATA_M = data[b];
      WSTRB_M = 4'($urandom);
      WLAST_M = (early >= 0) ? (b == early) : (b == int'(len));
      BREADY_M = 1'($urandom);
      for (int i = 0; i < NS; i++) begin
        WREADY_S[i] = tog ? ~WREADY_S[i] : 1'($urandom);
        BVALID_S[i] = 1'($urandom);
      end
      #1;
      chk("data_busy", busy, 1);
      chk("data_awready", AWREADY_M, 0);
      chk("data_bvalid", BVALID_M, 0);
      for (int i = 0; i < NS; i++) begin
        chk("data_awvalid_s", AWVALID_S[i], 0);
        chk("data_bready_s", BREADY_S[i], 0);
        if (i != s) begin
          chk("w_other_valid", WVALID_S[i], 0);
          chk("w_other_data", WDATA_S[i], 0);
        end
        if (WVALID_S[i] && WREADY_S[i]) got[i]++;
      end
      if (s < NS) begin
        chk("w_valid_s", WVALID_S[s], WVALID_M);
        chk("wready_m", WREADY_M, WREADY_S[s]);
        if (WVALID_M) begin
          chk("w_data_s", WDATA_S[s], data[b]);
          chk("w_strb_s", WSTRB_S[s], WSTRB_M);
        end
`ifdef AXI_WR_BEAT_CHECK_EN
        chk("w_last_s", WLAST_S[s], b == int'(len));
`else
        chk("w_last_s", WLAST_S[s], WLAST_M);
`endif
        acc = WVALID_M && WREADY_S[s];
      end else begin
        chk("wready_def", WREADY_M, 1);
        acc = WVALID_M;
      end
      if (acc) begin
        if (WLAST_M != (b == int'(len))) bad = 1;
        b++;
      end
      @(posedge clk);
    end
    if (b <= int'(len)) begin
      chk("w_timeout", 0, 1);
      $fatal(1, "w phase timeout");
    end
    for (int i = 0; i < NS; i++)
      chk("beats_at_slave", got[i], (i == s) ? int'(len) + 1 : 0);

    r = 2'($urandom_range(0, 2));
    er = (s == NS) ? 2'b11 : r;
`ifdef AXI_WR_BEAT_CHECK_EN
    if (bad && er != 2'b11) er = 2'b10;
`endif
    d = (s < NS) ? $urandom_range(0, 3) : 0;
    done = 0;
    for (cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      AWVALID_M = hold;
      AWADDR_M = hold ? 32'h0003_0000 : addr;
      WVALID_M = 1'($urandom);
      WLAST_M = 1'b0;
      BREADY_M = 1'($urandom);
      for (int i = 0; i < NS; i++) begin
        WREADY_S[i] = 1'($urandom);
        BVALID_S[i] = (i == s) ? (cyc >= d) : 1'($urandom);
        BID_S[i] = (i == s) ? {id, 4'($urandom)} : 8'($urandom);
        BRESP_S[i] = (i == s) ? r : 2'($urandom);
      end
      #1;
      chk("resp_busy", busy, 1);
      chk("resp_awready", AWREADY_M, 0);
      chk("resp_wready", WREADY_M, 0);
      for (int i = 0; i < NS; i++) begin
        chk("resp_awvalid_s", AWVALID_S[i], 0);
        chk("resp_wvalid_s", WVALID_S[i], 0);
        if (i != s) chk("resp_bready_other", BREADY_S[i], 0);
      end
      if (s < NS) begin
        chk("bvalid_m", BVALID_M, cyc >= d);
        chk("bready_s", BREADY_S[s], BREADY_M);
      end else begin
        chk("bvalid_def", BVALID_M, 1);
      end
      if (cyc >= d) begin
        chk("bid_m", BID_M, id);
        chk("bresp_m", BRESP_M, er);
      end
      done = (cyc >= d) && BREADY_M;
      @(posedge clk);
    end
    if (!done) begin
      chk("b_timeout", 0, 1);
      $fatal(1, "b phase timeout");
    end
  endtask

  initial begin
    rst = 1'b1;
    mid = '0; AWID_M = '0; AWADDR_M = '0; AWLEN_M = '0;
    AWSIZE_M = '0; AWBURST_M = '0; AWVALID_M = 1'b1;
    WDATA_M = '0; WSTRB_M = '0; WLAST_M = 1'b0; WVALID_M = 1'b1;
    BREADY_M = 1'b1;
    AWREADY_S = '1; WREADY_S = '0; BVALID_S = '1;
    for (int i = 0; i < NS; i++) begin
      BID_S[i] = 8'hFF;
      BRESP_S[i] = 2'b01;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", outs_any(), 0);
    @(negedge clk);
    rst = 1'b0;
    AWVALID_M = 1'b0;

    run_txn(32'h0000_1234, 4'd3, 4'd0, 4'd1, 0, -1, -1, 0);
    run_txn(32'h0001_0000, 4'd5, 4'd3, 4'($urandom), 1, -1, -1, 0);
    run_txn(32'h0002_0000, 4'd6, 4'd1, 4'd2, 0, -1, -1, 1);
    run_txn(32'h0005_0000, 4'd9, 4'd2, 4'd7, 0, -1, -1, 1);
    run_txn(32'h0004_0010, 4'hA, 4'd0, 4'd4, 0, -1, -1, 0);
    run_txn(32'h0001_0100, 4'd7, 4'd3, 4'd3, 0, -1, 1, 0);
    run_txn(32'h0000_0040, 4'd2, 4'd2, 4'd5, 0, -1, -1, 0);
`ifdef AXI_WR_BEAT_CHECK_EN
    run_txn(32'h0000_0080, 4'd4, 4'd3, 4'd1, 0, 1, -1, 0);
`endif
    for (int k = 0; k < 24; k++) begin
      run_txn({16'($urandom_range(0, 6)), 16'($urandom)}, 4'($urandom),
              4'($urandom_range(0, 7)), 4'($urandom), 1'($urandom),
              -1, -1, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
